// File: rtl/vinit_count_sum_pkg.sv
// Shared definitions for the counter-summation engine: FSM encoding and default widths.
package vinit_count_sum_pkg;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_SUM_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/vinit_dff_vec.sv
// W-bit enabled register with synchronous active-low clear to zero.
module vinit_dff_vec #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/vinit_count_sum_v2.sv
// Counter-summation engine: steps a counter n_terms times and accumulates each value.
// All state lives in vinit_dff_vec instances; this level holds only next-state logic and adders.
module vinit_count_sum_v2
  import vinit_count_sum_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] start_val,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             pause,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [SUM_W-1:0] sum,
  output logic             ovf
);
  if (SUM_W < CNT_W) begin : g_bad_width
    $error("vinit_count_sum_v2: SUM_W must be >= CNT_W");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, idx_q, idx_d, step_q, nt_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             accept, adv, last, upd, ovf_en;
  logic [SUM_W:0]   add;

  assign accept = (state_q == ST_IDLE) && start;
  assign adv    = (state_q == ST_RUN) && !pause;
  assign last   = (idx_q == nt_q - CNT_W'(1));
  assign upd    = accept || adv;

  // One extra bit on the adder so the carry-out feeds the sticky overflow flag.
  assign add = {1'b0, sum_q} + {{(SUM_W + 1 - CNT_W){1'b0}}, count_q};

  assign count_d = accept ? start_val : count_q + step_q;
  assign sum_d   = accept ? '0 : add[SUM_W-1:0];
  assign idx_d   = accept ? '0 : idx_q + CNT_W'(1);
  assign ovf_en  = accept || (adv && add[SUM_W]);
  assign ovf_d   = !accept;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (n_terms != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (adv && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  vinit_dff_vec #(.W(2)) u_state (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d), .q(state_q));
  vinit_dff_vec #(.W(CNT_W)) u_count (
    .clk(clk), .rst_n(rst_n), .en(upd), .d(count_d), .q(count_q));
  vinit_dff_vec #(.W(SUM_W)) u_sum (
    .clk(clk), .rst_n(rst_n), .en(upd), .d(sum_d), .q(sum_q));
  vinit_dff_vec #(.W(CNT_W)) u_idx (
    .clk(clk), .rst_n(rst_n), .en(upd), .d(idx_d), .q(idx_q));
  vinit_dff_vec #(.W(CNT_W)) u_step (
    .clk(clk), .rst_n(rst_n), .en(accept), .d(step), .q(step_q));
  vinit_dff_vec #(.W(CNT_W)) u_nt (
    .clk(clk), .rst_n(rst_n), .en(accept), .d(n_terms), .q(nt_q));
  vinit_dff_vec #(.W(1)) u_ovf (
    .clk(clk), .rst_n(rst_n), .en(ovf_en), .d(ovf_d), .q(ovf_q));

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign count = count_q;
  assign sum   = sum_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_vinit_count_sum_v2.sv
// Bench for vinit_count_sum_v2: a 16-bit-sum and an 8-bit-sum instance share stimulus;
// table vectors and hand sequences push expectations to a scoreboard popped on done.
module tb_vinit_count_sum_v2;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0, pause = 0;
  logic [7:0] start_val = 0, step = 0, n_terms = 0;
  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [7:0] count_a, count_b, sum_b;
  logic [15:0] sum_a;
  logic       sel = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vinit_count_sum_v2 #(.CNT_W(8), .SUM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .start_val(start_val), .step(step),
    .n_terms(n_terms), .pause(pause), .busy(busy_a), .done(done_a), .count(count_a),
    .sum(sum_a), .ovf(ovf_a));
  vinit_count_sum_v2 #(.CNT_W(8), .SUM_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .start_val(start_val), .step(step),
    .n_terms(n_terms), .pause(pause), .busy(busy_b), .done(done_b), .count(count_b),
    .sum(sum_b), .ovf(ovf_b));

  logic        busy_s, done_s, ovf_s;
  logic [7:0]  count_s;
  logic [15:0] sum_s;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign done_s  = sel ? done_b  : done_a;
  assign ovf_s   = sel ? ovf_b   : ovf_a;
  assign count_s = sel ? count_b : count_a;
  assign sum_s   = sel ? {8'd0, sum_b} : sum_a;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  count;
    logic        ovf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          s;
    logic [7:0]  sv, st, nt;
    int          pa, pl;
    bit          poke;
    logic [15:0] es;
    logic [7:0]  ec;
    logic        eo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: straightforward serial accumulation with wrap at 2^sw.
  task automatic model(input logic [7:0] sv, st, nt, input int sw,
                       output logic [15:0] s, output logic [7:0] c, output logic o);
    longint acc = 0;
    logic [7:0] cc = sv;
    o = 0;
    for (int i = 0; i < int'(nt); i++) begin
      acc += longint'(cc);
      if (acc >= (longint'(1) << sw)) begin
        acc -= (longint'(1) << sw);
        o = 1;
      end
      cc = cc + st;
    end
    s = acc[15:0];
    c = cc;
  endtask

  task automatic run_one(input vec_t v);
    exp_t e, g;
    int cyc, busy_n;
    logic [15:0] held;
    e.sum = v.es; e.count = v.ec; e.ovf = v.eo; e.lat = int'(v.nt) + v.pl;
    sb.push_back(e);
    sel = v.s;
    @(negedge clk);
    start = 1; start_val = v.sv; step = v.st; n_terms = v.nt;
    @(negedge clk);
    start = 0; start_val = 8'($urandom); step = 8'($urandom); n_terms = 8'($urandom);
    chk("load_sum", sum_s, 0);
    chk("load_count", count_s, v.sv);
    chk("load_ovf", ovf_s, 0);
    cyc = 0; busy_n = 0;
    while (!done_s && cyc < 400) begin
      if (busy_s) busy_n++;
      pause = (v.pl > 0) && (cyc >= v.pa) && (cyc < v.pa + v.pl);
      start = v.poke && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    pause = 0; start = 0;
    g = sb.pop_front();
    chk("done_seen", done_s, 1);
    chk("latency", cyc, g.lat);
    chk("busy_cycles", busy_n, g.lat);
    chk("sum", sum_s, g.sum);
    chk("count", count_s, g.count);
    chk("ovf", ovf_s, g.ovf);
    held = sum_s;
    start = v.poke;
    @(negedge clk);
    start = 0;
    chk("done_pulse", done_s, 0);
    chk("idle_busy", busy_s, 0);
    chk("sum_hold", sum_s, held);
  endtask

  initial begin
    vec_t vt[7];
    vec_t rv;
    int   dn;
    // {sel, start_val, step, n_terms, pause_at, pause_len, poke, sum, count, ovf}
    vt[0] = '{0, 8'd1,   8'd1, 8'd10, 0, 0, 0, 16'd55,  8'd11, 1'b0};
    vt[1] = '{0, 8'd9,   8'd3, 8'd0,  0, 0, 0, 16'd0,   8'd9,  1'b0};
    vt[2] = '{1, 8'd200, 8'd1, 8'd2,  0, 0, 0, 16'd145, 8'd202, 1'b1};
    vt[3] = '{1, 8'd5,   8'd2, 8'd3,  0, 0, 0, 16'd21,  8'd11, 1'b0};
    vt[4] = '{0, 8'd255, 8'd1, 8'd3,  0, 0, 0, 16'd256, 8'd2,  1'b0};
    vt[5] = '{0, 8'd3,   8'd1, 8'd5,  2, 3, 1, 16'd25,  8'd8,  1'b0};
    vt[6] = '{0, 8'd0,   8'd7, 8'd1,  0, 0, 0, 16'd0,   8'd7,  1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_sum", sum_a, 0);
    chk("rst_ovf", ovf_b, 0);
    rst_n = 1;

    for (int i = 0; i < 7; i++) run_one(vt[i]);

    for (int i = 0; i < 4; i++) begin
      rv.s = 0; rv.sv = 8'($urandom); rv.st = 8'($urandom); rv.nt = 8'($urandom_range(1, 20));
      rv.pa = $urandom_range(0, 5); rv.pl = $urandom_range(0, 3); rv.poke = 1;
      model(rv.sv, rv.st, rv.nt, 16, rv.es, rv.ec, rv.eo);
      run_one(rv);
    end

    // Mid-run reset on the narrow instance after its overflow has fired.
    sel = 1;
    @(negedge clk);
    start = 1; start_val = 8'd200; step = 8'd1; n_terms = 8'd10;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_ovf", ovf_b, 1);
    chk("pre_rst_busy", busy_a, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_sum", sum_a, 0);
    chk("mid_rst_ovf", ovf_b, 0);
    chk("mid_rst_sum_b", sum_b, 0);
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_a || done_b || busy_a) dn++;
    end
    chk("no_done_after_abort", dn, 0);
    run_one(vt[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
